// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_unit
// Description : ID-stage hazard unit for the 5-stage core. Handles forwarding,
//               load-use stalls, branch flushes and the scoreboard for the
//               non-pipelined MUL/DIV unit.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_unit #(
    parameter int LAT_MUL = 3,
    parameter int LAT_DIV = 8,
    parameter int CNT_W   = $clog2(((LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV) + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs1use_ID,
    input  logic       rs2use_ID,
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic [4:0] rd_ID,
    input  logic       we_ID,
    input  logic [2:0] optype_ID,
    input  logic       branch_taken_ID,
    input  logic [4:0] rd_EXE,
    input  logic [4:0] rd_MEM,
    input  logic       we_EXE,
    input  logic       we_MEM,
    input  logic       load_EXE,
    input  logic       we_WB,
    output logic       PC_EN_IF,
    output logic       reg_FD_EN,
    output logic       reg_DE_EN,
    output logic       reg_EM_EN,
    output logic       reg_MW_EN,
    output logic       reg_FD_flush,
    output logic       reg_DE_flush,
    output logic [1:0] forward_ctrl_A,
    output logic [1:0] forward_ctrl_B,
    output logic       mc_start,
    output logic       mc_wb_EN,
    output logic [4:0] mc_rd
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_mul_cnt = CNT_W'(LAT_MUL - 1);
    localparam logic [CNT_W-1:0] c_div_cnt = CNT_W'(LAT_DIV - 1);
    localparam logic [2:0]       c_op_mul  = 3'd3;
    localparam logic [2:0]       c_op_div  = 3'd4;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       mc_rd_q, mc_rd_d;

    logic       w_ld_use, w_raw_mc, w_waw_mc, w_struct, w_stall;
    logic       w_is_mc, w_issue, w_grant;
    logic [1:0] w_fwd_a, w_fwd_b;

    function automatic logic src_hit(input logic en, input logic [4:0] rs,
                                     input logic [4:0] rd);
        return en && (rs != 5'd0) && (rs == rd);
    endfunction

    assign w_is_mc  = (optype_ID == c_op_mul) || (optype_ID == c_op_div);
    assign w_ld_use = load_EXE && we_EXE &&
                      (src_hit(rs1use_ID, rs1_ID, rd_EXE) || src_hit(rs2use_ID, rs2_ID, rd_EXE));
    assign w_raw_mc = (state_q == ST_BUSY) &&
                      (src_hit(rs1use_ID, rs1_ID, mc_rd_q) || src_hit(rs2use_ID, rs2_ID, mc_rd_q));
    assign w_waw_mc = (state_q != ST_IDLE) && we_ID && (rd_ID != 5'd0) && (rd_ID == mc_rd_q);
    assign w_struct = w_is_mc && (state_q != ST_IDLE);
    assign w_stall  = w_ld_use || w_raw_mc || w_waw_mc || w_struct;
    assign w_issue  = w_is_mc && !w_stall && (state_q == ST_IDLE);
    assign w_grant  = (state_q == ST_DONE) && !we_WB;

    // A load in EXE has no data yet, so it never forwards from EXE.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (src_hit(rs1use_ID, rs1_ID, rd_EXE) && we_EXE && !load_EXE)  w_fwd_a = 2'b01;
        else if (src_hit(rs1use_ID, rs1_ID, rd_MEM) && we_MEM)         w_fwd_a = 2'b10;
        else if (src_hit(rs1use_ID, rs1_ID, mc_rd_q) && (state_q == ST_DONE)) w_fwd_a = 2'b11;
        if (src_hit(rs2use_ID, rs2_ID, rd_EXE) && we_EXE && !load_EXE)  w_fwd_b = 2'b01;
        else if (src_hit(rs2use_ID, rs2_ID, rd_MEM) && we_MEM)         w_fwd_b = 2'b10;
        else if (src_hit(rs2use_ID, rs2_ID, mc_rd_q) && (state_q == ST_DONE)) w_fwd_b = 2'b11;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_rd_d = mc_rd_q;
        case (state_q)
            ST_IDLE: begin
                if (w_issue) begin
                    state_d = ST_BUSY;
                    mc_rd_d = rd_ID;
                    cnt_d   = (optype_ID == c_op_div) ? c_div_cnt : c_mul_cnt;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_DONE: begin
                if (w_grant) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mc_rd_q <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mc_rd_q <= mc_rd_d;
        end
    end

    // While reset is asserted every control output sits at its idle value,
    // which also suppresses a write-back of a result about to be discarded.
    assign PC_EN_IF       = rst || !w_stall;
    assign reg_FD_EN      = rst || !w_stall;
    assign reg_DE_EN      = 1'b1;
    assign reg_EM_EN      = 1'b1;
    assign reg_MW_EN      = 1'b1;
    assign reg_FD_flush   = !rst && !w_stall && branch_taken_ID;
    assign reg_DE_flush   = !rst && (w_stall || w_issue);
    assign forward_ctrl_A = rst ? 2'b00 : w_fwd_a;
    assign forward_ctrl_B = rst ? 2'b00 : w_fwd_b;
    assign mc_start       = !rst && w_issue;
    assign mc_wb_EN       = !rst && w_grant;
    assign mc_rd          = mc_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard_unit
// Description : Self-checking bench: directed table, MC corner sequences and
//               random stimulus against a cycle-stamped scoreboard model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard_unit;

    localparam int LAT_MUL = 3;
    localparam int LAT_DIV = 8;

    logic       clk;
    logic       rst;
    logic       rs1use_ID, rs2use_ID, we_ID, branch_taken_ID;
    logic [4:0] rs1_ID, rs2_ID, rd_ID, rd_EXE, rd_MEM;
    logic [2:0] optype_ID;
    logic       we_EXE, we_MEM, load_EXE, we_WB;
    logic       PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN;
    logic       reg_FD_flush, reg_DE_flush, mc_start, mc_wb_EN;
    logic [1:0] forward_ctrl_A, forward_ctrl_B;
    logic [4:0] mc_rd;

    hazard_scoreboard_unit #(.LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)) dut (
        .clk(clk), .rst(rst),
        .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID), .we_ID(we_ID),
        .optype_ID(optype_ID), .branch_taken_ID(branch_taken_ID),
        .rd_EXE(rd_EXE), .rd_MEM(rd_MEM), .we_EXE(we_EXE), .we_MEM(we_MEM),
        .load_EXE(load_EXE), .we_WB(we_WB),
        .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN), .reg_DE_EN(reg_DE_EN),
        .reg_EM_EN(reg_EM_EN), .reg_MW_EN(reg_MW_EN),
        .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
        .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
        .mc_start(mc_start), .mc_wb_EN(mc_wb_EN), .mc_rd(mc_rd)
    );

    logic [17:0] got;
    assign got = {PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN,
                  reg_FD_flush, reg_DE_flush, forward_ctrl_A, forward_ctrl_B,
                  mc_start, mc_wb_EN, mc_rd};

    typedef struct {
        logic       rst, rs1use, rs2use, we, br, we_exe, ld_exe, we_mem, we_wb;
        logic [4:0] rs1, rs2, rd, rd_exe, rd_mem;
        logic [2:0] op;
    } in_t;

    typedef struct {
        in_t         i;
        logic [17:0] e;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    function automatic in_t mk(logic r, logic u1, logic [4:0] s1, logic u2, logic [4:0] s2,
                               logic w, logic [4:0] d, logic [2:0] o, logic b,
                               logic we_x, logic ld_x, logic [4:0] rd_x,
                               logic we_m, logic [4:0] rd_m, logic wb);
        in_t v;
        v.rst = r; v.rs1use = u1; v.rs1 = s1; v.rs2use = u2; v.rs2 = s2;
        v.we = w; v.rd = d; v.op = o; v.br = b;
        v.we_exe = we_x; v.ld_exe = ld_x; v.rd_exe = rd_x;
        v.we_mem = we_m; v.rd_mem = rd_m; v.we_wb = wb;
        return v;
    endfunction

    function automatic in_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [17:0] ex(logic stall, logic ffl, logic dfl, logic [1:0] fa,
                                       logic [1:0] fb, logic st, logic wb, logic [4:0] rd);
        return {!stall, !stall, 3'b111, ffl, dfl, fa, fb, st, wb, rd};
    endfunction

    // Reference model: one pending MC op with the cycle its result becomes ready.
    int         m_cyc   = 0;
    int         m_ready = 0;
    bit         m_pend  = 0;
    logic [4:0] m_rd    = 5'd0;

    function automatic bit reads(logic [4:0] r);
        return (rs1use_ID && rs1_ID != 0 && rs1_ID == r) ||
               (rs2use_ID && rs2_ID != 0 && rs2_ID == r);
    endfunction

    function automatic logic [1:0] fwd(logic en, logic [4:0] rs, bit done);
        if (!en || rs == 0)                   return 2'b00;
        if (we_EXE && !load_EXE && rs == rd_EXE) return 2'b01;
        if (we_MEM && rs == rd_MEM)           return 2'b10;
        if (done && rs == m_rd)               return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [17:0] model_out();
        bit busy  = m_pend && (m_cyc < m_ready);
        bit done  = m_pend && (m_cyc >= m_ready);
        bit mcop  = (optype_ID == 3) || (optype_ID == 4);
        bit stall = (load_EXE && we_EXE && reads(rd_EXE)) ||
                    (busy && reads(m_rd)) ||
                    (m_pend && we_ID && rd_ID != 0 && rd_ID == m_rd) ||
                    (mcop && m_pend);
        bit issue = mcop && !stall && !m_pend;
        if (rst) return {5'b11111, 2'b00, 4'b0000, 2'b00, m_rd};
        return {!stall, !stall, 3'b111, !stall && branch_taken_ID, stall || issue,
                fwd(rs1use_ID, rs1_ID, done), fwd(rs2use_ID, rs2_ID, done),
                issue, done && !we_WB, m_rd};
    endfunction

    always @(posedge clk) begin
        logic [17:0] o;
        o = model_out();
        if (rst) begin
            m_pend <= 0;
            m_rd   <= 5'd0;
        end else if (o[6]) begin
            m_pend  <= 1;
            m_rd    <= rd_ID;
            m_ready <= m_cyc + ((optype_ID == 4) ? LAT_DIV : LAT_MUL) + 1;
        end else if (o[5]) begin
            m_pend <= 0;
        end
        m_cyc <= m_cyc + 1;
    end

    task automatic apply(input in_t v);
        @(negedge clk);
        rst = v.rst; rs1use_ID = v.rs1use; rs1_ID = v.rs1; rs2use_ID = v.rs2use;
        rs2_ID = v.rs2; we_ID = v.we; rd_ID = v.rd; optype_ID = v.op;
        branch_taken_ID = v.br; we_EXE = v.we_exe; load_EXE = v.ld_exe;
        rd_EXE = v.rd_exe; we_MEM = v.we_mem; rd_MEM = v.rd_mem; we_WB = v.we_wb;
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
        n_vec++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, g, e);
        end
    endtask

    vec_t tbl[12];

    initial begin
        in_t v;
        rst = 1; rs1use_ID = 0; rs2use_ID = 0; rs1_ID = 0; rs2_ID = 0; rd_ID = 0;
        we_ID = 0; optype_ID = 0; branch_taken_ID = 0; rd_EXE = 0; rd_MEM = 0;
        we_EXE = 0; we_MEM = 0; load_EXE = 0; we_WB = 0;

        tbl[0]  = '{mk(0,1,5,1,1,1,6,0,0,1,1,5,0,0,0),  ex(1,0,1,0,0,0,0,0)};
        tbl[1]  = '{mk(0,1,5,1,1,1,6,0,0,0,0,0,1,5,0),  ex(0,0,0,2,0,0,0,0)};
        tbl[2]  = '{mk(0,1,3,0,0,1,4,0,0,1,0,3,1,3,0),  ex(0,0,0,1,0,0,0,0)};
        tbl[3]  = '{mk(0,1,0,0,0,1,4,0,0,1,0,0,1,0,0),  ex(0,0,0,0,0,0,0,0)};
        tbl[4]  = '{mk(0,1,2,1,3,0,0,0,1,0,0,0,0,0,0),  ex(0,1,0,0,0,0,0,0)};
        tbl[5]  = '{mk(0,1,5,0,0,1,6,0,1,1,1,5,0,0,0),  ex(1,0,1,0,0,0,0,0)};
        tbl[6]  = '{mk(0,1,4,1,9,1,10,0,0,1,0,4,1,9,0), ex(0,0,0,1,2,0,0,0)};
        tbl[7]  = '{mk(0,0,3,1,7,1,1,0,0,1,0,3,0,0,0),  ex(0,0,0,0,0,0,0,0)};
        tbl[8]  = '{mk(0,1,3,1,6,1,2,0,0,0,0,3,0,6,0),  ex(0,0,0,0,0,0,0,0)};
        tbl[9]  = '{mk(1,1,5,0,0,1,6,0,1,1,1,5,0,0,0),  ex(0,0,0,0,0,0,0,0)};
        tbl[10] = '{mk(0,0,0,0,0,1,7,5,0,0,0,0,0,0,0),  ex(0,0,0,0,0,0,0,0)};
        tbl[11] = '{mk(0,0,0,1,8,0,0,2,0,1,1,8,1,8,0),  ex(1,0,1,0,2,0,0,0)};

        apply(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        apply(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        chk("reset", got, ex(0,0,0,0,0,0,0,0));

        for (int k = 0; k < 12; k++) begin
            apply(tbl[k].i);
            chk($sformatf("table%0d", k), got, tbl[k].e);
        end

        // MUL to x7, dependent add x8,x7 waits then takes the MC result
        apply(mk(0,0,0,0,0,1,7,3,0,0,0,0,0,0,0));
        chk("mul_start", mc_start, 1);
        chk("mul_de_flush", reg_DE_flush, 1);
        chk("mul_pc_en", PC_EN_IF, 1);
        for (int k = 1; k <= LAT_MUL; k++) begin
            apply(mk(0,1,7,1,1,1,8,0,0,0,0,0,0,0,0));
            chk($sformatf("raw_stall_t%0d", k), PC_EN_IF, 0);
            chk("raw_no_wb", mc_wb_EN, 0);
        end
        apply(mk(0,1,7,1,1,1,8,0,0,0,0,0,0,0,0));
        chk("fwd_mc", forward_ctrl_A, 3);
        chk("mc_wb", mc_wb_EN, 1);
        chk("mc_rd", mc_rd, 7);
        chk("done_no_stall", PC_EN_IF, 1);
        apply(mk(0,1,7,1,1,1,8,0,0,0,0,0,0,0,0));
        chk("fwd_after", forward_ctrl_A, 0);
        chk("wb_after", mc_wb_EN, 0);

        // DIV to x9: structural, WAW, port conflict, back-to-back issue
        apply(mk(0,0,0,0,0,1,9,4,0,0,0,0,0,0,0));
        chk("div_start", mc_start, 1);
        apply(mk(0,0,0,0,0,1,10,3,0,0,0,0,0,0,0));
        chk("struct_busy", PC_EN_IF, 0);
        chk("struct_no_start", mc_start, 0);
        for (int k = 2; k <= LAT_DIV; k++) begin
            apply(nop());
            chk("div_busy_no_wb", mc_wb_EN, 0);
        end
        apply(mk(0,0,0,0,0,1,9,0,0,0,0,0,0,0,1));
        chk("waw_stall", PC_EN_IF, 0);
        chk("port_hold1", mc_wb_EN, 0);
        apply(mk(0,0,0,0,0,1,0,0,0,0,0,0,0,0,1));
        chk("waw_x0", PC_EN_IF, 1);
        chk("port_hold2", mc_wb_EN, 0);
        apply(mk(0,0,0,0,0,1,11,3,0,0,0,0,0,0,0));
        chk("port_grant", mc_wb_EN, 1);
        chk("struct_grant", PC_EN_IF, 0);
        chk("no_start_grant", mc_start, 0);
        apply(mk(0,0,0,0,0,1,11,3,0,0,0,0,0,0,0));
        chk("b2b_start", mc_start, 1);
        chk("b2b_pc_en", PC_EN_IF, 1);

        // Reset while BUSY discards the result
        apply(nop());
        chk("mc_rd_b2b", mc_rd, 11);
        apply(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        chk("rst_busy_wb", mc_wb_EN, 0);
        chk("rst_pc", PC_EN_IF, 1);
        for (int k = 0; k < 6; k++) begin
            apply(nop());
            chk("post_rst_wb", mc_wb_EN, 0);
            chk("post_rst_rd", mc_rd, 0);
        end

        for (int k = 0; k < 1500; k++) begin
            v = mk(($urandom_range(0, 63) == 0),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
            apply(v);
            chk($sformatf("rand%0d", k), got, model_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
